// File: rtl/core_serial_bridge_pkg.sv
// Shared constants and types for the core serial bridge and its bench.
package core_serial_bridge_pkg;

    localparam int unsigned MAIN_CORE_CMD_WHICH_SIZE  = 4;
    localparam int unsigned MAIN_CORE_SERIAL_CMD_SIZE = 16;
    localparam int unsigned CORE_CMD_W  = MAIN_CORE_CMD_WHICH_SIZE + MAIN_CORE_SERIAL_CMD_SIZE;
    localparam int unsigned CORE_CMD_NB = (CORE_CMD_W + 7) / 8;
    localparam int unsigned WORD_W      = 64;
    localparam int unsigned WORD_NB     = WORD_W / 8;

    // Frame type carried in header bits [7:6]
    typedef enum logic [1:0] {
        HDR_NOP = 2'b00,
        HDR_CMD = 2'b01,
        HDR_DAT = 2'b10,
        HDR_RSV = 2'b11
    } hdr_type_e;

    typedef enum logic [2:0] {
        RX_HDR,
        RX_CMD_B,
        RX_CMD_ISSUE,
        RX_DAT_B,
        RX_DAT_PUSH
    } rx_state_e;

    function automatic hdr_type_e hdr_type(input logic [7:0] b);
        return hdr_type_e'(b[7:6]);
    endfunction

endpackage

// File: rtl/core_serial_bridge_tx.sv
// Serializes one 64-bit core result into bytes, MSB first.
module core_serial_bridge_tx
    import core_serial_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready
);

    logic [WORD_W-1:0] shreg;
    logic [2:0]        remaining;

    // Load when empty, then shift out one byte per accepted tx transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            remaining  <= '0;
            tx_byte    <= '0;
            tx_valid   <= 1'b0;
            load_ready <= 1'b0;
        end else if (load_ready && load_valid) begin
            tx_byte    <= load_data[63:56];
            shreg      <= load_data << 8;
            remaining  <= 3'(WORD_NB - 1);
            tx_valid   <= 1'b1;
            load_ready <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            if (remaining == 3'd0) begin
                tx_byte    <= '0;
                tx_valid   <= 1'b0;
                load_ready <= 1'b1;
            end else begin
                tx_byte   <= shreg[63:56];
                shreg     <= shreg << 8;
                remaining <= remaining - 3'd1;
            end
        end else if (!tx_valid) begin
            load_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/core_serial_bridge.sv
// Host byte stream to core command/data bridge with independent result serializer.
module core_serial_bridge
    import core_serial_bridge_pkg::*;
#(
    parameter int unsigned CMD_W  = CORE_CMD_W,
    parameter int unsigned CMD_NB = (CMD_W + 7) / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_hasAny,
    input  logic              cmd_consume,
    output logic [63:0]       in,
    output logic              in_isReady,
    input  logic              in_canReceive,
    input  logic [63:0]       out,
    input  logic              out_isReady,
    output logic              out_canReceive
);

    localparam int unsigned CB_W   = CMD_NB * 8;
    localparam int unsigned BC_MAX = (CMD_NB > WORD_NB) ? CMD_NB : WORD_NB;
    localparam int unsigned BCNT_W = (BC_MAX > 1) ? $clog2(BC_MAX) : 1;

    rx_state_e         state;
    logic [BCNT_W-1:0] byte_cnt;
    logic [5:0]        word_cnt;
    logic [CB_W-1:0]   cmd_buf;
    logic [CB_W-1:0]   cmd_next;
    logic [55:0]       in_buf;
    logic [63:0]       in_next;
    logic              rx_fire;

    assign rx_fire  = rx_valid & rx_ready;
    // Command bytes arrive LSB first: shift in from the top
    assign cmd_next = (cmd_buf >> 8) | (CB_W'(rx_byte) << (CB_W - 8));
    // Data bytes arrive MSB first: shift in from the bottom
    assign in_next  = {in_buf, rx_byte};

    // RX frame FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_HDR;
            rx_ready   <= 1'b0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            cmd_buf    <= '0;
            cmd        <= '0;
            cmd_hasAny <= 1'b0;
            in_buf     <= '0;
            in         <= '0;
            in_isReady <= 1'b0;
        end else begin
            unique case (state)
                RX_HDR: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        byte_cnt <= '0;
                        case (hdr_type(rx_byte))
                            HDR_CMD: state <= RX_CMD_B;
                            HDR_DAT: begin
                                state    <= RX_DAT_B;
                                word_cnt <= rx_byte[5:0];
                            end
                            default: state <= RX_HDR;
                        endcase
                    end
                end
                RX_CMD_B: begin
                    if (rx_fire) begin
                        cmd_buf <= cmd_next;
                        if (byte_cnt == BCNT_W'(CMD_NB - 1)) begin
                            state      <= RX_CMD_ISSUE;
                            rx_ready   <= 1'b0;
                            cmd        <= CMD_W'(cmd_next);
                            cmd_hasAny <= 1'b1;
                            byte_cnt   <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + BCNT_W'(1);
                        end
                    end
                end
                RX_CMD_ISSUE: begin
                    if (cmd_consume) begin
                        state      <= RX_HDR;
                        rx_ready   <= 1'b1;
                        cmd        <= '0;
                        cmd_hasAny <= 1'b0;
                    end
                end
                RX_DAT_B: begin
                    if (rx_fire) begin
                        in_buf <= in_next[55:0];
                        if (byte_cnt == BCNT_W'(WORD_NB - 1)) begin
                            state      <= RX_DAT_PUSH;
                            rx_ready   <= 1'b0;
                            in         <= in_next;
                            in_isReady <= 1'b1;
                            byte_cnt   <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + BCNT_W'(1);
                        end
                    end
                end
                RX_DAT_PUSH: begin
                    if (in_canReceive) begin
                        in         <= '0;
                        in_isReady <= 1'b0;
                        rx_ready   <= 1'b1;
                        if (word_cnt == 6'd0) begin
                            state <= RX_HDR;
                        end else begin
                            state    <= RX_DAT_B;
                            word_cnt <= word_cnt - 6'd1;
                        end
                    end
                end
                default: begin
                    state    <= RX_HDR;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

    // Result path runs independently of the RX FSM
    core_serial_bridge_tx u_tx (
        .clk        (clk),
        .rst        (rst),
        .load_data  (out),
        .load_valid (out_isReady),
        .load_ready (out_canReceive),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

endmodule

// File: tb/tb_core_serial_bridge.sv
// Directed self-checking bench for core_serial_bridge.
module tb_core_serial_bridge;
    import core_serial_bridge_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            tx_byte;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [CORE_CMD_W-1:0] cmd;
    logic                  cmd_hasAny;
    logic                  cmd_consume;
    logic [63:0]           in_word;
    logic                  in_isReady;
    logic                  in_canReceive;
    logic [63:0]           out_word;
    logic                  out_isReady;
    logic                  out_canReceive;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        tx_toggle = 1'b0;
    logic [63:0] in_q[$];
    logic [7:0]  tx_q[$];

    core_serial_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_byte        (tx_byte),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .cmd            (cmd),
        .cmd_hasAny     (cmd_hasAny),
        .cmd_consume    (cmd_consume),
        .in             (in_word),
        .in_isReady     (in_isReady),
        .in_canReceive  (in_canReceive),
        .out            (out_word),
        .out_isReady    (out_isReady),
        .out_canReceive (out_canReceive)
    );

    always #5 clk = ~clk;

    // Host tx_ready: constant 1, or toggling 1/0 when requested
    always @(negedge clk) tx_ready = tx_toggle ? ~tx_ready : 1'b1;

    // Record completed transfers toward the core and the host
    always @(posedge clk) begin
        if (in_isReady === 1'b1 && in_canReceive === 1'b1) in_q.push_back(in_word);
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_byte);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called and returns at a negedge; the transfer happens at the posedge in between
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 7; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_tx;
        logic        early;
        int          n;

        rst = 1'b1; rx_byte = '0; rx_valid = 1'b0; cmd_consume = 1'b0;
        in_canReceive = 1'b1; out_word = '0; out_isReady = 1'b0;
        wait_cycles(3);

        // Reset state
        check_eq("rst_rx_ready", 64'(rx_ready), 64'd0);
        check_eq("rst_out_canReceive", 64'(out_canReceive), 64'd0);
        check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("rst_tx_byte", 64'(tx_byte), 64'd0);
        check_eq("rst_cmd", 64'(cmd), 64'd0);
        check_eq("rst_cmd_hasAny", 64'(cmd_hasAny), 64'd0);
        check_eq("rst_in", in_word, 64'd0);
        check_eq("rst_in_isReady", 64'(in_isReady), 64'd0);
        rst = 1'b0;
        wait_cycles(1);
        check_eq("post_rst_rx_ready", 64'(rx_ready), 64'd1);
        check_eq("post_rst_out_canReceive", 64'(out_canReceive), 64'd1);

        // Command frame, consume held off for five cycles
        send_byte({HDR_CMD, 6'd0});
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check_eq("cmd_rx_ready_low", 64'(rx_ready), 64'd0);
        check_eq("cmd_lsb", 64'(cmd[7:0]), 64'h11);
        for (int k = 0; k < 5; k++) begin
            check_eq("cmd_hasAny_held", 64'(cmd_hasAny), 64'd1);
            check_eq("cmd_value", 64'(cmd), 64'h3_2211);
            if (k == 4) cmd_consume = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        cmd_consume = 1'b0;
        check_eq("cmd_hasAny_dropped", 64'(cmd_hasAny), 64'd0);
        check_eq("cmd_cleared", 64'(cmd), 64'd0);
        check_eq("cmd_back_to_hdr", 64'(rx_ready), 64'd1);

        // Two-word data frame, first word stalled by the core
        in_q.delete();
        in_canReceive = 1'b0;
        send_byte(8'h81);
        send_word(64'h0102030405060708);
        wait_cycles(3);
        check_eq("dat_stall_isReady", 64'(in_isReady), 64'd1);
        check_eq("dat_stall_in", in_word, 64'h0102030405060708);
        check_eq("dat_stall_rx_ready", 64'(rx_ready), 64'd0);
        in_canReceive = 1'b1;
        send_word(64'h090A0B0C0D0E0F10);
        wait_cycles(4);
        check_eq("dat_count", 64'(in_q.size()), 64'd2);
        if (in_q.size() == 2) begin
            check_eq("dat_word0", in_q[0], 64'h0102030405060708);
            check_eq("dat_word1", in_q[1], 64'h090A0B0C0D0E0F10);
        end
        check_eq("dat_in_idle_zero", in_word, 64'd0);
        check_eq("dat_isReady_idle", 64'(in_isReady), 64'd0);

        // Result serialization with toggling tx_ready
        tx_q.delete();
        tx_toggle   = 1'b1;
        out_word    = 64'hDEADBEEF01234567;
        out_isReady = 1'b1;
        @(negedge clk);
        out_isReady = 1'b0;
        out_word    = '0;
        early = 1'b0;
        n = 0;
        while (tx_q.size() < 8 && n < 200) begin
            if (out_canReceive !== 1'b0) early = 1'b1;
            @(negedge clk);
            n++;
        end
        check_eq("tx_count", 64'(tx_q.size()), 64'd8);
        check_eq("tx_busy_blocks_load", 64'(early), 64'd0);
        check_eq("tx_free_after_last", 64'(out_canReceive), 64'd1);
        exp_tx = 64'hDEADBEEF01234567;
        for (int i = 0; i < 8; i++)
            if (i < tx_q.size()) check_eq("tx_byte_order", 64'(tx_q[i]), 64'(exp_tx[63 - i*8 -: 8]));
        tx_toggle = 1'b0;
        wait_cycles(2);

        // NOP and reserved headers are ignored
        in_q.delete();
        send_byte({HDR_NOP, 6'd0});
        send_byte(8'hC5);
        send_byte(8'h80);
        send_word(64'hF0F1F2F3F4F5F6F7);
        wait_cycles(4);
        check_eq("nop_rsv_count", 64'(in_q.size()), 64'd1);
        if (in_q.size() == 1) check_eq("nop_rsv_word", in_q[0], 64'hF0F1F2F3F4F5F6F7);
        check_eq("nop_rsv_no_cmd", 64'(cmd_hasAny), 64'd0);

        // Reset mid-word discards the partial frame
        in_q.delete();
        send_byte(8'h80);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        send_byte(8'h80);
        send_word(64'hAAAAAAAAAAAAAAAA);
        wait_cycles(4);
        check_eq("rst_mid_count", 64'(in_q.size()), 64'd1);
        if (in_q.size() == 1) check_eq("rst_mid_word", in_q[0], 64'hAAAAAAAAAAAAAAAA);

        // Data frame and result word proceed in parallel
        in_q.delete();
        tx_q.delete();
        fork
            begin
                send_byte(8'h81);
                send_word(64'h1122334455667788);
                send_word(64'h99AABBCCDDEEFF00);
            end
            begin
                wait_cycles(3);
                out_word    = 64'h0123456789ABCDEF;
                out_isReady = 1'b1;
                @(negedge clk);
                out_isReady = 1'b0;
                out_word    = '0;
            end
        join
        wait_cycles(6);
        check_eq("par_in_count", 64'(in_q.size()), 64'd2);
        if (in_q.size() == 2) begin
            check_eq("par_word0", in_q[0], 64'h1122334455667788);
            check_eq("par_word1", in_q[1], 64'h99AABBCCDDEEFF00);
        end
        check_eq("par_tx_count", 64'(tx_q.size()), 64'd8);
        exp_tx = 64'h0123456789ABCDEF;
        for (int i = 0; i < 8; i++)
            if (i < tx_q.size()) check_eq("par_tx_byte", 64'(tx_q[i]), 64'(exp_tx[63 - i*8 -: 8]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_serial_bridge.md
CORE_SERIAL_BRIDGE -- requirements
Module: core_serial_bridge

Interface
REQ-001 SHALL have parameter CMD_W, default `MainCoreCMD_which_SIZE+`MainCoreSerialCMD_SIZE, core command width.
REQ-002 SHALL have parameter CMD_NB, default ceil(CMD_W/8), number of command payload bytes.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  in  1  clock, all logic on rising edge.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: rx_byte  in  8  host byte stream data.
REQ-007 Port: rx_valid  in  1  rx_byte valid.
REQ-008 Port: rx_ready  out  1  bridge accepts rx_byte; transfer when rx_valid&rx_ready at posedge.
REQ-009 Port: tx_byte  out  8  reply byte stream data.
REQ-010 Port: tx_valid  out  1  tx_byte valid.
REQ-011 Port: tx_ready  in  1  host accepts; transfer when tx_valid&tx_ready at posedge.
REQ-012 Port: cmd  out  CMD_W  command to core.
REQ-013 Port: cmd_hasAny  out  1  command pending.
REQ-014 Port: cmd_consume  in  1  core takes command at posedge when cmd_hasAny high.
REQ-015 Port: in  out  64  data word to core.
REQ-016 Port: in_isReady  out  1  data word valid; transfer when in_isReady&in_canReceive at posedge.
REQ-017 Port: in_canReceive  in  1  core can accept a word.
REQ-018 Port: out  in  64  result word from core.
REQ-019 Port: out_isReady  in  1  result word valid.
REQ-020 Port: out_canReceive  out  1  bridge accepts result; transfer when out_isReady&out_canReceive at posedge.

Function
REQ-021 RX FSM states: HDR, CMD_B, CMD_ISSUE, DAT_B, DAT_PUSH; SHALL start in HDR.
REQ-022 HDR: rx_ready=1; header bits[7:6]: 00 NOP (stay HDR), 01 -> CMD_B, 10 -> DAT_B with word count N=hdr[5:0]+1 (1..64), 11 reserved (ignored, stay HDR).
REQ-023 CMD_B: rx_ready=1; accepts CMD_NB bytes, first byte -> cmd[7:0], LSB first; bits beyond CMD_W dropped; after last byte -> CMD_ISSUE next cycle.
REQ-024 CMD_ISSUE: rx_ready=0, cmd_hasAny=1, cmd stable; on cmd_consume at posedge -> HDR, cmd_hasAny=0 and cmd=0 from next cycle.
REQ-025 DAT_B: rx_ready=1; 8 bytes per word, first byte -> in[63:56] (MSB first); after 8th byte -> DAT_PUSH next cycle.
REQ-026 DAT_PUSH: rx_ready=0, in_isReady=1, in stable; on transfer, decrement word count; -> DAT_B if words remain else HDR; in=0 when in_isReady=0.
REQ-027 TX path SHALL be independent of RX FSM; both may transfer in the same cycle.
REQ-028 out_canReceive SHALL be 1 only when TX shift register empty; on transfer, tx_valid=1 next cycle with out[63:56], then [55:48] ... [7:0], one byte per tx transfer.
REQ-029 Stalls: rx_valid=0 or tx_ready=0 hold state indefinitely, no data loss or duplication.
REQ-030 Byte counter 0..7 and word counter SHALL not wrap; exact count terminates phase.

Reset
REQ-031 rst SHALL return RX FSM to HDR, clear counters and TX shift register, discarding partial frames/words.
REQ-032 Outputs during and after reset: rx_ready=0 during rst then 1; tx_valid=0; tx_byte=0; cmd=0; cmd_hasAny=0; in=0; in_isReady=0; out_canReceive=0 during rst then 1.

Structure
REQ-033 Header type codes (NOP/CMD/DAT/RSV), CMD_W and CMD_NB SHALL live in a shared defines header included by bridge and bench.
REQ-034 TX serializer SHALL be sub-module core_serial_bridge_tx (64-bit load, 8-bit valid/ready out).

Verification
REQ-035 Bytes 0x40 then CMD_NB bytes 0x11,0x22,... ; cmd_consume delayed 5 cycles -> cmd_hasAny held 5 cycles, cmd LSB byte 0x11, dropped 1 cycle after consume.
REQ-036 Bytes 0x81 then 01..10 hex; in_canReceive=1 -> two words 0x0102030405060708, 0x090A0B0C0D0E0F10, in order.
REQ-037 Core out=0xDEADBEEF01234567, tx_ready toggling 1/0 -> tx bytes DE,AD,BE,EF,01,23,45,67; out_canReceive=0 until last byte taken.
REQ-038 Bytes 0x00, 0xC5, then 0x80 + 8 bytes -> NOP/reserved ignored, exactly one data word pushed.
REQ-039 rst after 3 bytes of a data word, then 0x80 + AA x8 -> only 0xAAAAAAAAAAAAAAAA pushed.
REQ-040 Data frame pushing while core out word arrives -> both paths complete in parallel, no stall coupling.
